numero_arbiter: RTL and testbench
=================================

NUMERO_ARBITER -- requirements
Module: numero_arbiter

Interface
REQ-001 Parameter: HOLD_CYCLES, default 4, legal range 1..65535, number of cycles a granted selection is held before re-arbitration.
REQ-002 clk  input  1  single system clock; all state updates on rising edge.
REQ-003 reset_n  input  1  reset, asynchronous, active-low.
REQ-004 reqC  input  1  level request from Celsius source to drive numero.
REQ-005 reqF  input  1  level request from Fahrenheit source to drive numero.
REQ-006 mode  input  2  00/11 round-robin, 01 Celsius only, 10 Fahrenheit only.
REQ-007 En  output  1  select to numero mux; 1 = numeroC, 0 = numeroF.
REQ-008 ackC  output  1  one-cycle grant pulse to Celsius source.
REQ-009 ackF  output  1  one-cycle grant pulse to Fahrenheit source.
REQ-010 load  output  1  one-cycle strobe: numero stable, downstream latches it.
REQ-011 busy  output  1  high whenever state is not IDLE.

Function
REQ-012 FSM states SHALL be IDLE, GRANT, LOAD, HOLD; all outputs registered.
REQ-013 IDLE: eligible requests sampled each edge; none eligible -> stay IDLE, En unchanged.
REQ-014 Eligibility: mode 01 -> reqC only; mode 10 -> reqF only; 00/11 -> both.
REQ-015 One eligible request -> grant it; both eligible -> grant the source not granted last (round-robin via last_grant register).
REQ-016 IDLE->GRANT on edge with eligible request; during GRANT cycle ack of winner = 1, En = winner (C->1, F->0), last_grant updated.
REQ-017 GRANT->LOAD unconditionally; load = 1 for exactly that cycle; En unchanged.
REQ-018 LOAD->HOLD; 16-bit counter loaded with HOLD_CYCLES-1, decremented each HOLD cycle; HOLD lasts exactly HOLD_CYCLES cycles.
REQ-019 HOLD->IDLE when counter = 0; En retains last grant through HOLD and IDLE.
REQ-020 Minimum ack-to-ack spacing SHALL be HOLD_CYCLES+3 cycles (GRANT, LOAD, HOLD x N, IDLE).
REQ-021 Requests are level; a request still high after its ack is a new request at next IDLE; requester deasserts on ack to avoid re-grant.
REQ-022 Requests changing during GRANT/LOAD/HOLD SHALL be ignored until IDLE; no queueing beyond the current levels.
REQ-023 mode changes mid-grant SHALL not alter En or timing; take effect at next IDLE sample.
REQ-024 Ineligible requests (forced mode) SHALL never be acked and remain pending, not dropped.
REQ-025 ackC and ackF SHALL never be high in the same cycle; at most one of ack/load high per cycle.

Reset
REQ-026 reset_n low SHALL immediately force: state IDLE, En=0, ackC=0, ackF=0, load=0, busy=0, counter=0, last_grant=F.
REQ-027 Reset asserted mid-GRANT/LOAD/HOLD SHALL abort the cycle; no ack or load pulse completes after reset asserts.
REQ-028 After reset release, first simultaneous reqC/reqF in round-robin SHALL grant C.

Verification
REQ-029 Reset, then reqC=reqF=1 held, mode=00, HOLD_CYCLES=4 -> ackC at cycle 1 (En=1), load cycle 2, ackF at cycle 8 (En=0), ackC at cycle 15; strict alternation.
REQ-030 mode=01, reqF=1 only for 20 cycles -> no ackF, En stays 0, busy=0; then set mode=00 -> ackF next IDLE-sample cycle.
REQ-031 reqC pulse single cycle while HOLD active -> ignored, no ackC after HOLD ends.
REQ-032 reset_n low during LOAD cycle of a C grant -> load drops at once, En=0, busy=0; after release no stale ack/load.
REQ-033 HOLD_CYCLES=1, reqF held high -> ackF every 4 cycles, load exactly one cycle after each ackF.
REQ-034 All runs: assertion checks ackC&ackF never 1, load always exactly one cycle after an ack, En constant outside GRANT cycles.

Source files
------------

// File: rtl/numero_arbiter.sv
// Two-source arbiter for the shared numero bus: picks Celsius or Fahrenheit,
// pulses ack then load, and holds the selection for HOLD_CYCLES before re-arbitrating.
module numero_arbiter #(
    parameter int unsigned HOLD_CYCLES = 4
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       reqC,
    input  logic       reqF,
    input  logic [1:0] mode,
    output logic       En,
    output logic       ackC,
    output logic       ackF,
    output logic       load,
    output logic       busy
);

    typedef enum logic [1:0] {IDLE, GRANT, LOAD, HOLD} state_t;

    localparam logic [15:0] HOLD_LAST = 16'(HOLD_CYCLES - 1);

    state_t      state_q;
    logic [15:0] cnt_q;
    logic        last_c_q;
    logic        en_q, ackc_q, ackf_q, load_q, busy_q;

    logic        elig_c_d, elig_f_d, pick_c_d;

    // Forced modes mask the other source; 00 and 11 both mean round-robin.
    assign elig_c_d = reqC && (mode != 2'b10);
    assign elig_f_d = reqF && (mode != 2'b01);
    // Contention goes to whichever source did not win last time.
    assign pick_c_d = elig_c_d && (!elig_f_d || !last_c_q);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            last_c_q <= 1'b0;
            en_q     <= 1'b0;
            ackc_q   <= 1'b0;
            ackf_q   <= 1'b0;
            load_q   <= 1'b0;
            busy_q   <= 1'b0;
        end else begin
            ackc_q <= 1'b0;
            ackf_q <= 1'b0;
            load_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (elig_c_d || elig_f_d) begin
                        state_q  <= GRANT;
                        busy_q   <= 1'b1;
                        en_q     <= pick_c_d;
                        ackc_q   <= pick_c_d;
                        ackf_q   <= !pick_c_d;
                        last_c_q <= pick_c_d;
                    end
                end
                GRANT: begin
                    state_q <= LOAD;
                    load_q  <= 1'b1;
                end
                LOAD: begin
                    state_q <= HOLD;
                    cnt_q   <= HOLD_LAST;
                end
                HOLD: begin
                    // Counter reaches zero on the last of HOLD_CYCLES hold cycles.
                    if (cnt_q == 16'd0) begin
                        state_q <= IDLE;
                        busy_q  <= 1'b0;
                    end else begin
                        cnt_q <= cnt_q - 16'd1;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign En   = en_q;
    assign ackC = ackc_q;
    assign ackF = ackf_q;
    assign load = load_q;
    assign busy = busy_q;

endmodule

// File: tb/tb_numero_arbiter.sv
// Bench for numero_arbiter: HOLD_CYCLES=4 and =1 instances on shared stimulus,
// checked every cycle against a grant-timeline model plus literal cycle expectations.
module tb_numero_arbiter;

    logic       clk = 1'b0;
    logic       reset_n = 1'b0;
    logic       reqC = 1'b0, reqF = 1'b0;
    logic [1:0] mode = 2'b00;
    logic       en4, ackc4, ackf4, load4, busy4;
    logic       en1, ackc1, ackf1, load1, busy1;

    int tests = 0;
    int fails = 0;
    int cur = 0;

    int ack4_cyc[$], ack4_c[$], load4_cyc[$];
    int ack1_cyc[$], ack1_c[$], load1_cyc[$];

    typedef struct {
        int n;
        int gcyc;
        bit gc;
        bit en;
        bit lastc;
        bit pen;
        bit pack;
        bit pvalid;
    } mdl_t;

    mdl_t m4, m1;

    numero_arbiter #(.HOLD_CYCLES(4)) u_h4 (
        .clk(clk), .reset_n(reset_n), .reqC(reqC), .reqF(reqF), .mode(mode),
        .En(en4), .ackC(ackc4), .ackF(ackf4), .load(load4), .busy(busy4)
    );

    numero_arbiter #(.HOLD_CYCLES(1)) u_h1 (
        .clk(clk), .reset_n(reset_n), .reqC(reqC), .reqF(reqF), .mode(mode),
        .En(en1), .ackC(ackc1), .ackF(ackf1), .load(load1), .busy(busy1)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic int qget(input int q[$], input int i);
        if (i < q.size()) return q[i];
        return -1;
    endfunction

    // Timeline model: a grant at cycle g owns cycles g..g+1+H (ack, load, hold),
    // and the arbiter next looks at requests in cycle g+H+2.
    task automatic step(inout mdl_t m, input int h, input string tag,
                        input logic en, input logic ac, input logic af,
                        input logic ld, input logic by);
        logic [4:0] exp;
        bit ec, ef;
        if (!reset_n) begin
            chk({tag, " reset outputs"}, 32'({en, ac, af, ld, by}), 32'(0));
            m.n = 0; m.gcyc = -1000; m.gc = 0; m.en = 0; m.lastc = 0;
            m.pen = 0; m.pack = 0; m.pvalid = 0;
            return;
        end
        if (m.n == m.gcyc) m.en = m.gc;
        exp = {m.en, (m.n == m.gcyc) && m.gc, (m.n == m.gcyc) && !m.gc,
               m.n == m.gcyc + 1, (m.n >= m.gcyc) && (m.n <= m.gcyc + 1 + h)};
        chk({tag, " {En,ackC,ackF,load,busy}"}, 32'({en, ac, af, ld, by}), 32'(exp));
        chk({tag, " ackC&ackF"}, 32'(ac & af), 32'(0));
        if (m.pvalid) begin
            chk({tag, " load after ack"}, 32'(ld), 32'(m.pack));
            if (!(ac || af)) chk({tag, " En stable"}, 32'(en), 32'(m.pen));
        end
        ec = reqC && (mode != 2'b10);
        ef = reqF && (mode != 2'b01);
        if ((m.n >= m.gcyc + h + 2) && (ec || ef)) begin
            m.gc    = ec && (!ef || !m.lastc);
            m.lastc = m.gc;
            m.gcyc  = m.n + 1;
        end
        m.pack = ac | af;
        m.pen = en;
        m.pvalid = 1;
        m.n++;
    endtask

    always @(negedge clk) begin
        if (reset_n) begin
            if (ackc4 || ackf4) begin ack4_cyc.push_back(m4.n); ack4_c.push_back(int'(ackc4)); end
            if (load4) load4_cyc.push_back(m4.n);
            if (ackc1 || ackf1) begin ack1_cyc.push_back(m1.n); ack1_c.push_back(int'(ackc1)); end
            if (load1) load1_cyc.push_back(m1.n);
        end else begin
            ack4_cyc.delete(); ack4_c.delete(); load4_cyc.delete();
            ack1_cyc.delete(); ack1_c.delete(); load1_cyc.delete();
        end
        step(m4, 4, "h4", en4, ackc4, ackf4, load4, busy4);
        step(m1, 1, "h1", en1, ackc1, ackf1, load1, busy1);
    end

    // Reset with the given input levels; cycle 0 is the first IDLE cycle after release.
    task automatic apply_reset(input logic c, input logic f, input logic [1:0] md);
        @(posedge clk); #1;
        reset_n = 1'b0;
        reqC = c; reqF = f; mode = md;
        #1 chk("reset state h4", 32'({en4, ackc4, ackf4, load4, busy4}), 32'(0));
        repeat (2) @(posedge clk);
        #1 reset_n = 1'b1;
        cur = 0;
    endtask

    task automatic to_cycle(input int k);
        repeat (k - cur) @(posedge clk);
        #1 cur = k;
    endtask

    initial begin
        // Both requesting, round-robin: C first after reset, then strict alternation.
        apply_reset(1'b1, 1'b1, 2'b00);
        to_cycle(30);
        chk("rr h4 ack0 cyc", 32'(qget(ack4_cyc, 0)), 32'(1));
        chk("rr h4 ack0 C",   32'(qget(ack4_c, 0)),   32'(1));
        chk("rr h4 load0",    32'(qget(load4_cyc, 0)), 32'(2));
        chk("rr h4 ack1 cyc", 32'(qget(ack4_cyc, 1)), 32'(8));
        chk("rr h4 ack1 C",   32'(qget(ack4_c, 1)),   32'(0));
        chk("rr h4 ack2 cyc", 32'(qget(ack4_cyc, 2)), 32'(15));
        chk("rr h4 ack2 C",   32'(qget(ack4_c, 2)),   32'(1));
        chk("rr h4 load1",    32'(qget(load4_cyc, 1)), 32'(9));
        chk("rr h1 ack1 cyc", 32'(qget(ack1_cyc, 1)), 32'(5));
        chk("rr h1 ack2 C",   32'(qget(ack1_c, 2)),   32'(1));

        // Celsius-only mode starves F without dropping it; round-robin then grants F.
        apply_reset(1'b0, 1'b1, 2'b01);
        to_cycle(20);
        chk("forced no ack",  32'(ack4_cyc.size()), 32'(0));
        chk("forced En",      32'(en4), 32'(0));
        chk("forced busy",    32'(busy4), 32'(0));
        mode = 2'b00;
        to_cycle(23);
        chk("release ackF cyc", 32'(qget(ack4_cyc, 0)), 32'(21));
        chk("release ackF C",   32'(qget(ack4_c, 0)),   32'(0));

        // Single-cycle C pulse during HOLD is ignored by the H=4 arbiter.
        apply_reset(1'b1, 1'b0, 2'b00);
        to_cycle(1);
        reqC = 1'b0;
        to_cycle(4);
        reqC = 1'b1;
        to_cycle(5);
        reqC = 1'b0;
        to_cycle(16);
        chk("pulse h4 acks", 32'(ack4_cyc.size()), 32'(1));
        chk("pulse h1 acks", 32'(ack1_cyc.size()), 32'(2));
        chk("pulse h1 ack1", 32'(qget(ack1_cyc, 1)), 32'(5));

        // Reset during the LOAD cycle of a C grant aborts everything immediately.
        apply_reset(1'b1, 1'b0, 2'b00);
        to_cycle(1);
        reqC = 1'b0;
        @(posedge clk);
        #2 reset_n = 1'b0;
        #1;
        chk("abort load", 32'(load4), 32'(0));
        chk("abort En",   32'(en4),   32'(0));
        chk("abort busy", 32'({busy4, busy1}), 32'(0));
        @(posedge clk);
        #1 reset_n = 1'b1;
        cur = 0;
        to_cycle(10);
        chk("abort no ack",  32'(ack4_cyc.size() + ack1_cyc.size()), 32'(0));
        chk("abort no load", 32'(load4_cyc.size() + load1_cyc.size()), 32'(0));

        // F held alone: H=1 grants every 4 cycles, H=4 every 7.
        apply_reset(1'b0, 1'b1, 2'b00);
        to_cycle(16);
        for (int i = 0; i < 4; i++) begin
            chk($sformatf("h1 ackF%0d cyc", i), 32'(qget(ack1_cyc, i)), 32'(1 + 4 * i));
            chk($sformatf("h1 ackF%0d C", i),   32'(qget(ack1_c, i)),   32'(0));
            chk($sformatf("h1 load%0d", i),     32'(qget(load1_cyc, i)), 32'(2 + 4 * i));
        end
        chk("h4 ackF2 cyc", 32'(qget(ack4_cyc, 2)), 32'(15));

        // Mode change mid-grant applies at the next IDLE; ineligible C stays pending.
        apply_reset(1'b1, 1'b1, 2'b00);
        to_cycle(3);
        mode = 2'b01;
        to_cycle(9);
        chk("mid-mode ack1 cyc", 32'(qget(ack4_cyc, 1)), 32'(8));
        chk("mid-mode ack1 C",   32'(qget(ack4_c, 1)),   32'(1));
        mode = 2'b10;
        reqF = 1'b0;
        to_cycle(25);
        chk("pending C unacked", 32'(ack4_cyc.size()), 32'(2));
        mode = 2'b00;
        to_cycle(28);
        chk("pending C ack cyc", 32'(qget(ack4_cyc, 2)), 32'(26));
        chk("pending C ack C",   32'(qget(ack4_c, 2)),   32'(1));

        to_cycle(40);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
